// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART command parser: ASCII command codes and TX FSM encoding.
package uart_cmd_parser_pkg;

    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_r     = 8'h72;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_c     = 8'h63;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_m     = 8'h6D;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_u     = 8'h75;
    localparam logic [7:0] CH_D     = 8'h44;
    localparam logic [7:0] CH_d     = 8'h64;
    localparam logic [7:0] CH_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_cmd_parser_fifo.sv
// Small circular echo FIFO; head word is visible on dout whenever not empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign dout  = mem[rd_ptr_reg];

    // A pop in the same cycle frees the slot, so a push on full is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes received ASCII command bytes into one-cycle pulses and echoes them to the UART transmitter.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit ECHO_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_err,
    output logic       overflow
);
    tx_state_t  state_reg;
    tx_state_t  state_next;
    logic       hit_run;
    logic       hit_clear;
    logic       hit_mode;
    logic       hit_up;
    logic       hit_down;
    logic       known;
    logic [7:0] echo_byte;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    assign hit_run   = (rx_data == CH_R) || (rx_data == CH_r);
    assign hit_clear = (rx_data == CH_C) || (rx_data == CH_c);
    assign hit_mode  = (rx_data == CH_M) || (rx_data == CH_m);
    assign hit_up    = (rx_data == CH_U) || (rx_data == CH_u);
    assign hit_down  = (rx_data == CH_D) || (rx_data == CH_d);
    assign known     = hit_run || hit_clear || hit_mode || hit_up || hit_down;
    assign echo_byte = known ? rx_data : CH_QMARK;
    assign push      = ECHO_EN && rx_done;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_echo_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (echo_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            cmd_run   <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
            cmd_up    <= 1'b0;
            cmd_down  <= 1'b0;
            cmd_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_start  <= pop;
            if (pop) begin
                tx_data <= fifo_dout;
            end
            cmd_run   <= rx_done && hit_run;
            cmd_clear <= rx_done && hit_clear;
            cmd_mode  <= rx_done && hit_mode;
            cmd_up    <= rx_done && hit_up;
            cmd_down  <= rx_done && hit_down;
            cmd_err   <= rx_done && !known;
            // The command pulse is still issued when its echo is dropped.
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench: echo-enabled and echo-disabled parsers share one stimulus stream.
module tb_uart_cmd_parser;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy;
    logic       tx_start, cmd_run, cmd_clear, cmd_mode, cmd_up, cmd_down, cmd_err, overflow;
    logic [7:0] tx_data;
    logic       tx_busy_ne = 1'b0;
    logic       tx_start_ne, cmd_run_ne, cmd_clear_ne, cmd_mode_ne, cmd_up_ne, cmd_down_ne;
    logic       cmd_err_ne, overflow_ne;
    logic [7:0] tx_data_ne;
    logic [5:0] cmd_vec, cmd_vec_ne;

    uart_cmd_parser #(.FIFO_DEPTH(DEPTH), .ECHO_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .cmd_run(cmd_run), .cmd_clear(cmd_clear),
        .cmd_mode(cmd_mode), .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_err(cmd_err),
        .overflow(overflow)
    );

    uart_cmd_parser #(.FIFO_DEPTH(DEPTH), .ECHO_EN(1'b0)) dut_ne (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy_ne),
        .tx_start(tx_start_ne), .tx_data(tx_data_ne), .cmd_run(cmd_run_ne),
        .cmd_clear(cmd_clear_ne), .cmd_mode(cmd_mode_ne), .cmd_up(cmd_up_ne),
        .cmd_down(cmd_down_ne), .cmd_err(cmd_err_ne), .overflow(overflow_ne)
    );

    assign cmd_vec    = {cmd_run, cmd_clear, cmd_mode, cmd_up, cmd_down, cmd_err};
    assign cmd_vec_ne = {cmd_run_ne, cmd_clear_ne, cmd_mode_ne, cmd_up_ne, cmd_down_ne, cmd_err_ne};

    always #5 clk = ~clk;

    // Transmitter model: busy starts the cycle after tx_start and lasts a fixed or random length.
    int busy_left = 0;
    bit hold_busy = 1'b0;
    bit rand_len  = 1'b0;
    always @(posedge clk) begin
        if (tx_start) busy_left <= rand_len ? int'($urandom_range(1, 12)) : 10;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = hold_busy || (busy_left > 0);

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] echo_q[$];
    logic [5:0] exp_cmd = 6'd0;
    logic       rst_q = 1'b1;
    logic [7:0] tx_data_prev = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // Echo scoreboard and tx_data stability monitor.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (tx_start === 1'b1) begin
            if (echo_q.size() == 0) begin
                check("unexpected_tx_start", 32'(tx_start), 32'd0);
            end else begin
                exp_b = echo_q.pop_front();
                check("echo_data", 32'(tx_data), 32'(exp_b));
                $display("echo tx_data=%02h", tx_data);
            end
        end else if (!rst_q) begin
            check("tx_data_hold", 32'(tx_data), 32'(tx_data_prev));
        end
        check("ne_tx_start", 32'(tx_start_ne), 32'd0);
        tx_data_prev <= tx_data;
    end

    function automatic logic [5:0] model_cmd(input logic [7:0] b);
        logic [7:0] u;
        u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        case (u)
            8'h52:   return 6'b100000;
            8'h43:   return 6'b010000;
            8'h4D:   return 6'b001000;
            8'h55:   return 6'b000100;
            8'h44:   return 6'b000010;
            default: return 6'b000001;
        endcase
    endfunction

    function automatic logic [7:0] model_echo(input logic [7:0] b);
        logic [5:0] c;
        c = model_cmd(b);
        return c[0] ? 8'h3F : b;
    endfunction

    // One cycle: check last cycle's expected pulses, then drive this cycle's rx.
    task automatic cyc(input bit do_rx, input logic [7:0] b, input logic [5:0] ec,
                       input bit push_echo, input logic [7:0] ee);
        @(negedge clk);
        check("cmd", 32'(cmd_vec), 32'(exp_cmd));
        check("cmd_ne", 32'(cmd_vec_ne), 32'(exp_cmd));
        rx_done = do_rx;
        rx_data = do_rx ? b : 8'h00;
        exp_cmd = do_rx ? ec : 6'd0;
        if (do_rx) $display("rx %02h exp_cmd=%06b", b, ec);
        if (do_rx && push_echo) echo_q.push_back(ee);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 6'd0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        idle(1);
        rst = 1'b1;
        echo_q.delete();
        idle(1);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 3000; i++) begin
            if (echo_q.size() == 0 && !tx_busy) break;
            idle(1);
        end
        check(nm, 32'(echo_q.size()), 32'd0);
        idle(3);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [5:0] cmd;
        logic [7:0] echo;
    } vec_t;
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{8'h5A, 6'b000001, 8'h3F};
        tbl[1]  = '{8'h52, 6'b100000, 8'h52};
        tbl[2]  = '{8'h63, 6'b010000, 8'h63};
        tbl[3]  = '{8'h43, 6'b010000, 8'h43};
        tbl[4]  = '{8'h4D, 6'b001000, 8'h4D};
        tbl[5]  = '{8'h6D, 6'b001000, 8'h6D};
        tbl[6]  = '{8'h55, 6'b000100, 8'h55};
        tbl[7]  = '{8'h75, 6'b000100, 8'h75};
        tbl[8]  = '{8'h44, 6'b000010, 8'h44};
        tbl[9]  = '{8'h64, 6'b000010, 8'h64};
        tbl[10] = '{8'h00, 6'b000001, 8'h3F};
        tbl[11] = '{8'hF2, 6'b000001, 8'h3F};
        tbl[12] = '{8'h3F, 6'b000001, 8'h3F};
        tbl[13] = '{8'h53, 6'b000001, 8'h3F};

        do_reset();
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_ne_overflow", 32'(overflow_ne), 32'd0);

        // 'r': cmd_run next cycle, tx_start two cycles after rx_done
        cyc(1'b1, 8'h72, 6'b100000, 1'b1, 8'h72);
        idle(1);
        check("t1_no_early_start", 32'(tx_start), 32'd0);
        idle(1);
        check("t1_tx_start", 32'(tx_start), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h72);
        check("t1_overflow", 32'(overflow), 32'd0);
        wait_drain("t1_drain");

        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].data, tbl[i].cmd, 1'b1, tbl[i].echo);
            idle(1);
            wait_drain("tbl_drain");
        end

        // "CMUDc" back to back with the transmitter held busy: fifth echo dropped
        do_reset();
        hold_busy = 1'b1;
        cyc(1'b1, 8'h43, 6'b010000, 1'b1, 8'h43);
        cyc(1'b1, 8'h4D, 6'b001000, 1'b1, 8'h4D);
        cyc(1'b1, 8'h55, 6'b000100, 1'b1, 8'h55);
        cyc(1'b1, 8'h44, 6'b000010, 1'b1, 8'h44);
        cyc(1'b1, 8'h63, 6'b010000, 1'b0, 8'h63);
        idle(2);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_ne", 32'(overflow_ne), 32'd0);
        hold_busy = 1'b0;
        wait_drain("ovf_drain");
        idle(20);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop in the same cycle while full: nothing dropped
        do_reset();
        check("pp_overflow_cleared", 32'(overflow), 32'd0);
        hold_busy = 1'b1;
        cyc(1'b1, 8'h52, 6'b100000, 1'b1, 8'h52);
        cyc(1'b1, 8'h43, 6'b010000, 1'b1, 8'h43);
        cyc(1'b1, 8'h4D, 6'b001000, 1'b1, 8'h4D);
        cyc(1'b1, 8'h55, 6'b000100, 1'b1, 8'h55);
        idle(3);
        cyc(1'b1, 8'h44, 6'b000010, 1'b1, 8'h44);
        hold_busy = 1'b0;
        idle(2);
        check("pp_no_overflow", 32'(overflow), 32'd0);
        wait_drain("pp_drain");
        check("pp_overflow_end", 32'(overflow), 32'd0);

        // Reset while in WAIT_DONE with two bytes queued
        do_reset();
        cyc(1'b1, 8'h75, 6'b000100, 1'b1, 8'h75);
        cyc(1'b1, 8'h64, 6'b000010, 1'b1, 8'h64);
        cyc(1'b1, 8'h78, 6'b000001, 1'b1, 8'h3F);
        for (int i = 0; i < 50; i++) begin
            if (tx_busy) break;
            idle(1);
        end
        check("rst_busy_seen", 32'(tx_busy), 32'd1);
        idle(2);
        do_reset();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cmds", 32'(cmd_vec), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        idle(100);
        cyc(1'b1, 8'h6D, 6'b001000, 1'b1, 8'h6D);
        idle(1);
        wait_drain("rst_recover_drain");

        // Randomized traffic against the reference model
        rand_len = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            if (echo_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 11))
                    0: b = 8'h52;  1: b = 8'h72;  2: b = 8'h43;  3: b = 8'h63;
                    4: b = 8'h4D;  5: b = 8'h6D;  6: b = 8'h55;  7: b = 8'h75;
                    8: b = 8'h44;  9: b = 8'h64;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                cyc(1'b1, b, model_cmd(b), 1'b1, model_echo(b));
            end else begin
                idle(1);
            end
        end
        idle(1);
        rand_len = 1'b0;
        wait_drain("rand_drain");
        check("rand_overflow", 32'(overflow), 32'd0);
        check("rand_ne_overflow", 32'(overflow_ne), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and feeds the UART transmitter in the dual-watch design.
- Takes received bytes (rx_data qualified by rx_done) and decodes single-character ASCII commands into one-cycle control pulses for the watch/stopwatch logic.
- Echoes each accepted byte (or '?' for an unknown one) back through the transmitter using the tx_start/tx_busy handshake.
- A small echo FIFO decouples the receive rate from transmit completion.

Parameters:
- FIFO_DEPTH, 4, echo FIFO entries; power of two, minimum 2.
- ECHO_EN, 1, 1 = echo enabled; 0 = no bytes pushed and tx_start is never asserted.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte; valid only in the rx_done cycle
- rx_done  input  1  one-cycle pulse marking a new received byte
- tx_busy  input  1  transmitter busy; high while a frame is in flight
- tx_start  output  1  one-cycle pulse that starts a transmitter frame
- tx_data  output  8  byte to transmit; held stable from the tx_start cycle until tx_busy falls
- cmd_run  output  1  pulse on 'R' or 'r' (run/stop toggle)
- cmd_clear  output  1  pulse on 'C' or 'c'
- cmd_mode  output  1  pulse on 'M' or 'm' (watch/stopwatch select)
- cmd_up  output  1  pulse on 'U' or 'u' (increment selected field)
- cmd_down  output  1  pulse on 'D' or 'd' (decrement selected field)
- cmd_err  output  1  pulse on any other byte
- overflow  output  1  sticky flag; set when an echo byte is dropped because the FIFO is full

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All cmd_* = 0, tx_start = 0, tx_data = 8'h00, overflow = 0.
  - FIFO emptied; FSM to IDLE.
  - Reset mid-frame abandons the current echo; the transmitter finishes its own frame independently.
- Decode:
  - Registered; the cmd_* pulse is asserted in the cycle after rx_done, for exactly 1 cycle.
  - Exactly one cmd_* output is high per rx_done.
  - Back-to-back rx_done in consecutive cycles gives back-to-back pulses.
- Echo push (ECHO_EN=1):
  - In the rx_done cycle, push rx_data for known commands and 8'h3F ('?') for unknown ones.
  - If FIFO full: byte dropped, overflow set to 1 and held until reset. The command pulse is still issued.
- Echo FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, plus a count of $clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: both occur, count unchanged, legal even when full (a pop in the same cycle frees the slot, so no drop).
  - Pop on empty never occurs.
- TX FSM:
  - IDLE: if FIFO not empty and tx_busy == 0, pop the head into tx_data, assert tx_start for 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy == 1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy == 0, then go to IDLE.
  - Minimum gap: one IDLE cycle between tx_busy falling and the next tx_start.
  - Latency from rx_done to tx_start when idle and empty: 2 cycles (push cycle, then IDLE sees not-empty).
- tx_data changes only in the tx_start cycle.
- Arithmetic: case-insensitivity via exact compare against both codes; no other byte transformation.

Decomposition:
- Shared package holds:
  - ASCII command constants: CH_R=8'h52, CH_r=8'h72, CH_C, CH_c, CH_M, CH_m, CH_U, CH_u, CH_D, CH_d, CH_QMARK=8'h3F.
  - TX FSM state encoding: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2.
- One sub-module: sync_fifo (parameter DEPTH, WIDTH=8; ports clk, rst, push, pop, din, dout, full, empty).
- The parser holds the decode and TX FSM.

Test Plan:
- Reset, then rx_done with 8'h72 ('r'), transmitter model raising tx_busy 1 cycle after tx_start for 10 cycles:
  - cmd_run pulses 1 cycle after rx_done.
  - tx_start 2 cycles after rx_done with tx_data = 8'h72.
  - overflow = 0.
- rx_done with 8'h5A ('Z'):
  - cmd_err pulse; all other cmd_* stay 0.
  - Echoed tx_data = 8'h3F.
- Five rx_done pulses "CMUDc" on consecutive cycles with tx_busy held high (FIFO_DEPTH=4):
  - Five distinct cmd pulses in order.
  - 5th byte dropped and overflow = 1.
  - After release, echoes 'C','M','U','D' in order with no duplicates.
- Push in the same cycle as pop while the FIFO is full:
  - No drop, overflow stays 0, count stays 4.
- Assert rst while in WAIT_DONE with 2 bytes queued:
  - Next cycle all outputs are 0, FIFO is empty, and no further tx_start occurs.
- ECHO_EN=0, send 'm':
  - cmd_mode pulses; tx_start never asserted over 100 cycles.
